systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Input-staging stage that sits directly upstream of the systolic PE array. It sequences weight loading into the array's top ports while driving the array's loadingWeights line. It then streams activation rows into the side ports with the per-row diagonal skew the wavefront needs. Finally it drains the array with zeros and signals completion to the controller.

Parameters:
inputBits, 8, width of each weight/activation operand
ROWS, 2, array rows (side inputs), ≥1
COLS, 2, array columns (top inputs), ≥1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a job; sampled in IDLE only
reuse_w  input  1  sampled with start; 1 = skip weight load, keep array weights
w_valid  input  1  weight beat valid
w_ready  output  1  weight beat accepted when w_valid&w_ready
w_data  input  COLS*inputBits  one weight row; column j at [j*inputBits +: inputBits]
act_valid  input  1  activation beat valid
act_ready  output  1  activation beat accepted when act_valid&act_ready
act_a  input  ROWS*inputBits  a operand per row r at [r*inputBits +: inputBits]
act_b  input  ROWS*inputBits  b operand per row, same packing
act_last  input  1  marks final activation beat of the job
top_c  output  COLS*inputBits  to array in_top_j_c, same packing as w_data
side_a  output  ROWS*inputBits  to array in_side_r_a
side_b  output  ROWS*inputBits  to array in_side_r_b
loadingWeights  output  1  to array loadingWeights
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset (rst=0, async): FSM→IDLE; all skew/output registers cleared; top_c, side_a, side_b, loadingWeights, w_ready, act_ready, busy, done all 0. Takes effect immediately mid-job; no partial flush.
- States: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: start=1 → LOAD_W (reuse_w=0) or STREAM (reuse_w=1). start in any other state is ignored.
- LOAD_W: w_ready=1. Exactly ROWS beats are accepted; beat 0 carries weights for row ROWS-1 (bottom row first). Each accepted beat appears on top_c one cycle later, together with loadingWeights=1. On cycles with no accepted beat, top_c=0 and loadingWeights=0, so the array weights do not advance. After beat ROWS-1 is accepted → STREAM.
- STREAM: act_ready=1. An accepted beat enters the skew line; no accepted beat enters a zero bubble. Row r output is registered with latency r+1 cycles from acceptance: row 0 = 1 cycle, row 1 = 2 cycles, etc. a and b share identical skew. Bubbles keep their slot, so rows stay diagonally aligned. Accepting a beat with act_last=1 → DRAIN. side_a/side_b carry only accepted data or zero, never stale values.
- DRAIN: act_ready=0. Zeros are injected for D = 2*ROWS+COLS-2 cycles, counted by a down-counter loaded on entry (D=4 for 2x2). The counter reaches 0 → IDLE with done=1 for exactly that cycle.
- In STREAM and DRAIN, loadingWeights=0 and top_c=0. In LOAD_W, side_a=side_b=0.
- Back-to-back jobs: start may be asserted in the cycle after done; the skew line is already all-zero at that point.
- Edge case ROWS=1: no skew beyond the single output register; D=COLS.

Test Plan:
- Reset: hold rst=0 with random inputs → all outputs 0, busy=0. Release, then start with no beats → busy=1, w_ready=1, loadingWeights stays 0.
- Weight load, ROWS=COLS=2, inputBits=8: start, reuse_w=0, accept w_data=0x0201 then 0x0403 on consecutive cycles → top_c=0x0201, then 0x0403, with loadingWeights=1 for those 2 cycles only; act_ready=1 in the cycle after the second beat.
- Weight backpressure: w_valid low for 2 cycles between the two beats → loadingWeights=0 and top_c=0 in the gap; exactly 2 loadingWeights cycles total.
- Skew + drain: reuse_w=1 start; accept act_a row0/row1 = (0x01,0x05) at T and (0x02,0x06, last) at T+1 → side_a row0 = 0x01@T+1, 0x02@T+2; row1 = 0x05@T+2, 0x06@T+3; zeros elsewhere; done pulse at T+5.
- Bubble: act_valid low for one cycle between beats 1 and 2 → a zero slot appears in row0 and in row1, one cycle apart; subsequent data keeps the diagonal.
- Reset mid-STREAM: assert rst after 1 accepted beat → side_a/side_b=0 immediately, busy=0, no done. A new start afterwards runs cleanly with no residual data.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Handshake and array-facing bundle for the systolic feeder.
// master = job controller / data source, slave = the feeder itself.
interface systolic_feeder_if #(
  parameter int inputBits = 8,
  parameter int ROWS      = 2,
  parameter int COLS      = 2
);
  logic                      start;
  logic                      reuse_w;
  logic                      w_valid;
  logic                      w_ready;
  logic [COLS*inputBits-1:0] w_data;
  logic                      act_valid;
  logic                      act_ready;
  logic [ROWS*inputBits-1:0] act_a;
  logic [ROWS*inputBits-1:0] act_b;
  logic                      act_last;
  logic [COLS*inputBits-1:0] top_c;
  logic [ROWS*inputBits-1:0] side_a;
  logic [ROWS*inputBits-1:0] side_b;
  logic                      loadingWeights;
  logic                      busy;
  logic                      done;

  modport master (
    output start, reuse_w, w_valid, w_data, act_valid, act_a, act_b, act_last,
    input  w_ready, act_ready, top_c, side_a, side_b, loadingWeights, busy, done
  );

  modport slave (
    input  start, reuse_w, w_valid, w_data, act_valid, act_a, act_b, act_last,
    output w_ready, act_ready, top_c, side_a, side_b, loadingWeights, busy, done
  );
endinterface

// File: rtl/systolic_feeder.sv
// Stages weights into the array top ports, streams diagonally skewed activation
// rows into the side ports, then drains the array with zeros and flags done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; skew line is all zero
// S_LOAD_W | accepting ROWS weight beats, bottom row first
// S_STREAM | accepting activation beats until act_last
// S_DRAIN  | injecting zeros for 2*ROWS+COLS-2 cycles, done on the last
module systolic_feeder #(
  parameter int inputBits = 8,
  parameter int ROWS      = 2,
  parameter int COLS      = 2
) (
  input logic             clk,
  input logic             rst,
  systolic_feeder_if.slave bus
);

  localparam int DRAIN_CYC = 2*ROWS + COLS - 2;
  localparam int DCW       = $clog2(DRAIN_CYC + 1);
  localparam int WCW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RW        = ROWS*inputBits;
  localparam int CW        = COLS*inputBits;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WCW-1:0] r_wcnt;
  logic [DCW-1:0] r_dcnt;
  logic [CW-1:0]  r_top_c;
  logic           r_loading;
  logic           w_w_ready;
  logic           w_act_ready;
  logic           w_done;
  logic           w_w_acc;
  logic           w_a_acc;
  wire  [RW-1:0]  w_side_a;
  wire  [RW-1:0]  w_side_b;

  always_comb begin
    w_state_nxt = r_state;
    w_w_ready   = 1'b0;
    w_act_ready = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = bus.reuse_w ? S_STREAM : S_LOAD_W;
      end
      S_LOAD_W: begin
        w_w_ready = 1'b1;
        if (bus.w_valid && (r_wcnt == '0)) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        w_act_ready = 1'b1;
        if (bus.act_valid && bus.act_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_dcnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_w_acc = w_w_ready & bus.w_valid;
  assign w_a_acc = w_act_ready & bus.act_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Both counters run down to a terminal count of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt <= '0;
      r_dcnt <= '0;
    end else begin
      if (r_state == S_IDLE)  r_wcnt <= WCW'(ROWS-1);
      else if (w_w_acc)       r_wcnt <= r_wcnt - WCW'(1);
      if (w_a_acc && bus.act_last)                 r_dcnt <= DCW'(DRAIN_CYC-1);
      else if (r_state == S_DRAIN && r_dcnt != '0) r_dcnt <= r_dcnt - DCW'(1);
    end
  end

  // Weights only reach the array on cycles with an accepted beat, so the
  // array's weight chain never shifts on a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_top_c   <= '0;
      r_loading <= 1'b0;
    end else begin
      r_top_c   <= w_w_acc ? bus.w_data : '0;
      r_loading <= w_w_acc;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [inputBits-1:0] r_sa [0:r];
    logic [inputBits-1:0] r_sb [0:r];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) begin
          r_sa[k] <= '0;
          r_sb[k] <= '0;
        end
      end else begin
        r_sa[0] <= w_a_acc ? bus.act_a[r*inputBits +: inputBits] : '0;
        r_sb[0] <= w_a_acc ? bus.act_b[r*inputBits +: inputBits] : '0;
        for (int k = 1; k <= r; k++) begin
          r_sa[k] <= r_sa[k-1];
          r_sb[k] <= r_sb[k-1];
        end
      end
    end

    assign w_side_a[r*inputBits +: inputBits] = r_sa[r];
    assign w_side_b[r*inputBits +: inputBits] = r_sb[r];
  end

  assign bus.w_ready        = w_w_ready;
  assign bus.act_ready      = w_act_ready;
  assign bus.top_c          = r_top_c;
  assign bus.loadingWeights = r_loading;
  assign bus.side_a         = w_side_a;
  assign bus.side_b         = w_side_b;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = w_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed cycle table plus randomized traffic,
// both checked every cycle against a job-level reference model.
module tb_systolic_feeder;
  localparam int IB = 8;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int D  = 2*R + C - 2;
  localparam int RW = R*IB;
  localparam int CW = C*IB;

  logic clk;
  logic rst;

  systolic_feeder_if #(.inputBits(IB), .ROWS(R), .COLS(C)) bus ();

  systolic_feeder #(.inputBits(IB), .ROWS(R), .COLS(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ci = {start, reuse_w, w_valid}; ca = {act_valid, act_last}
  // ef = {busy, w_ready, act_ready, loadingWeights}
  typedef struct {
    logic [2:0]    ci;
    logic [CW-1:0] wd;
    logic [1:0]    ca;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [3:0]    ef;
    logic [CW-1:0] et;
    logic [RW-1:0] esa;
    logic [RW-1:0] esb;
    logic          ed;
  } vec_t;

  vec_t tbl[$];
  vec_t nov;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: job phase, weight beats remaining, absolute cycle of done,
  // and a history of what was accepted on each previous cycle.
  int            m_phase;
  int            m_wleft;
  int            m_cyc;
  int            m_done_cyc;
  logic [CW-1:0] m_top;
  logic          m_ld;
  logic [RW-1:0] qa[$];
  logic [RW-1:0] qb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_wleft = 0;
    m_top   = '0;
    m_ld    = 1'b0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < R; i++) begin
      qa.push_back('0);
      qb.push_back('0);
    end
  endtask

  task automatic model_step();
    logic acc_w, acc_a;
    acc_w = (m_phase == 1) && bus.w_valid;
    acc_a = (m_phase == 2) && bus.act_valid;
    m_top = acc_w ? bus.w_data : '0;
    m_ld  = acc_w;
    qa.push_front(acc_a ? bus.act_a : '0);
    qb.push_front(acc_a ? bus.act_b : '0);
    void'(qa.pop_back());
    void'(qb.pop_back());
    case (m_phase)
      0: if (bus.start) begin
           if (bus.reuse_w) m_phase = 2;
           else begin m_phase = 1; m_wleft = R; end
         end
      1: if (acc_w) begin
           m_wleft--;
           if (m_wleft == 0) m_phase = 2;
         end
      2: if (acc_a && bus.act_last) begin
           m_phase    = 3;
           m_done_cyc = m_cyc + D;
         end
      default: if (m_cyc == m_done_cyc) m_phase = 0;
    endcase
    m_cyc++;
  endtask

  task automatic tick(input bit use_tbl, input vec_t v);
    logic [RW-1:0] e_sa, e_sb, ta, tb_;
    logic          e_done;
    #1;
    if (!rst) model_clear();
    e_sa = '0;
    e_sb = '0;
    for (int r = 0; r < R; r++) begin
      ta  = qa[r];
      tb_ = qb[r];
      e_sa[r*IB +: IB] = ta[r*IB +: IB];
      e_sb[r*IB +: IB] = tb_[r*IB +: IB];
    end
    e_done = (m_phase == 3) && (m_cyc == m_done_cyc);
    chk("busy",      64'(bus.busy),           64'(m_phase != 0));
    chk("w_ready",   64'(bus.w_ready),        64'(m_phase == 1));
    chk("act_ready", 64'(bus.act_ready),      64'(m_phase == 2));
    chk("loadingW",  64'(bus.loadingWeights), 64'(m_ld));
    chk("top_c",     64'(bus.top_c),          64'(m_top));
    chk("side_a",    64'(bus.side_a),         64'(e_sa));
    chk("side_b",    64'(bus.side_b),         64'(e_sb));
    chk("done",      64'(bus.done),           64'(e_done));
    if (use_tbl) begin
      chk("tbl_busy",   64'(bus.busy),           64'(v.ef[3]));
      chk("tbl_wready", 64'(bus.w_ready),        64'(v.ef[2]));
      chk("tbl_aready", 64'(bus.act_ready),      64'(v.ef[1]));
      chk("tbl_loadW",  64'(bus.loadingWeights), 64'(v.ef[0]));
      chk("tbl_top_c",  64'(bus.top_c),          64'(v.et));
      chk("tbl_side_a", 64'(bus.side_a),         64'(v.esa));
      chk("tbl_side_b", 64'(bus.side_b),         64'(v.esb));
      chk("tbl_done",   64'(bus.done),           64'(v.ed));
    end
    if (rst) model_step();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.reuse_w   = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.act_valid = 1'b0;
    bus.act_a     = '0;
    bus.act_b     = '0;
    bus.act_last  = 1'b0;
  endtask

  task automatic drive_random();
    bus.start     = ($urandom_range(0, 3) == 0);
    bus.reuse_w   = ($urandom_range(0, 1) == 1);
    bus.w_valid   = ($urandom_range(0, 2) != 0);
    bus.w_data    = CW'($urandom);
    bus.act_valid = ($urandom_range(0, 3) != 0);
    bus.act_a     = RW'($urandom);
    bus.act_b     = RW'($urandom);
    bus.act_last  = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    // Directed flow: weight load, skew + drain, back-to-back job with a
    // weight stall and an activation bubble, then a reuse_w job.
    tbl.push_back('{3'b100, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b001, 16'h0201, 2'b00, 16'h0000, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b001, 16'h0403, 2'b00, 16'h0000, 16'h0000, 4'b1101, 16'h0201, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b10, 16'h0501, 16'h1511, 4'b1011, 16'h0403, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b11, 16'h0602, 16'h1612, 4'b1010, 16'h0000, 16'h0001, 16'h0011, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b11, 16'hFFFF, 16'hFFFF, 4'b1000, 16'h0000, 16'h0502, 16'h1512, 1'b0});
    tbl.push_back('{3'b111, 16'hEEEE, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0600, 16'h1600, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{3'b100, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b001, 16'hA1B2, 2'b00, 16'h0000, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1101, 16'hA1B2, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b001, 16'hC3D4, 2'b00, 16'h0000, 16'h0000, 4'b1100, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b10, 16'h2010, 16'h4030, 4'b1011, 16'hC3D4, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1010, 16'h0000, 16'h0010, 16'h0030, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b11, 16'h2111, 16'h4131, 4'b1010, 16'h0000, 16'h2000, 16'h4000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0011, 16'h0031, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h2100, 16'h4100, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{3'b110, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b11, 16'h0807, 16'h2827, 4'b1010, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b100, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0007, 16'h0027, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0800, 16'h2800, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b0});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b1000, 16'h0000, 16'h0000, 16'h0000, 1'b1});
    tbl.push_back('{3'b000, 16'h0000, 2'b00, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 1'b0});

    rst = 1'b0;
    drive_idle();
    model_clear();
    m_cyc      = 0;
    m_done_cyc = 0;
    @(negedge clk);

    // Reset held with random inputs: everything must stay zero.
    for (int i = 0; i < 4; i++) begin
      drive_random();
      tick(1'b0, nov);
    end

    // Start with no weight beats: busy, w_ready high, weights never advance.
    rst = 1'b1;
    drive_idle();
    tick(1'b0, nov);
    bus.start = 1'b1;
    tick(1'b0, nov);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, nov);
    rst = 1'b0;
    tick(1'b0, nov);
    rst = 1'b1;

    foreach (tbl[i]) begin
      {bus.start, bus.reuse_w, bus.w_valid} = tbl[i].ci;
      bus.w_data                            = tbl[i].wd;
      {bus.act_valid, bus.act_last}         = tbl[i].ca;
      bus.act_a                             = tbl[i].a;
      bus.act_b                             = tbl[i].b;
      tick(1'b1, tbl[i]);
    end

    // Reset in the middle of a stream, then a clean follow-up job.
    drive_idle();
    bus.start   = 1'b1;
    bus.reuse_w = 1'b1;
    tick(1'b0, nov);
    drive_idle();
    bus.act_valid = 1'b1;
    bus.act_a     = 16'h5A3C;
    bus.act_b     = 16'h7E21;
    tick(1'b0, nov);
    drive_idle();
    tick(1'b0, nov);
    rst = 1'b0;
    #1;
    chk("mid_rst_side_a", 64'(bus.side_a), 64'h0);
    chk("mid_rst_side_b", 64'(bus.side_b), 64'h0);
    chk("mid_rst_busy",   64'(bus.busy),   64'h0);
    chk("mid_rst_done",   64'(bus.done),   64'h0);
    tick(1'b0, nov);
    rst = 1'b1;
    bus.start   = 1'b1;
    bus.reuse_w = 1'b1;
    tick(1'b0, nov);
    drive_idle();
    bus.act_valid = 1'b1;
    bus.act_last  = 1'b1;
    bus.act_a     = 16'h3344;
    bus.act_b     = 16'h5566;
    tick(1'b0, nov);
    drive_idle();
    for (int i = 0; i < D + 2; i++) tick(1'b0, nov);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      drive_random();
      rst = ($urandom_range(0, 149) != 0);
      tick(1'b0, nov);
    end
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 12; i++) tick(1'b0, nov);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
